// File: rtl/pipe_core_param.sv
// Parametrised five-stage pipeline (IF/ID/EX/MEM/WB) with EX forwarding, load-use stall, EX-resolved flush and hold.
// Optional macro ZERO_REG_EN makes R0 a hard-wired zero register.
module pipe_core_param #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);

`ifdef ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif
    localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

    typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluOr} aluOpT;

    logic [DATA_W-1:0] rf [16];

    logic [PC_W-1:0]   pc, pcD;
    logic [15:0]       instD;

    logic              exRegWrite, exMemRead, exMemWrite, exBeq, exJmp, exUseImm;
    aluOpT             exAluOp;
    logic [3:0]        exRd, exRs1, exRsB, exImm;
    logic [DATA_W-1:0] exA, exB;
    logic [PC_W-1:0]   exTarget;

    logic              memRegWrite, memMemRead, memMemWrite;
    logic [3:0]        memRd;
    logic [DATA_W-1:0] memAlu, memStore;

    logic              wbRegWrite;
    logic [3:0]        wbRd;
    logic [DATA_W-1:0] wbData;

    logic [3:0]        idOp, idRd, idRs1, idRsB;
    logic              idRegWrite, idMemRead, idMemWrite, idBeq, idJmp, idUseImm, idUseA, idUseB;
    aluOpT             idAluOp;
    logic [DATA_W-1:0] idA, idB;
    logic [PC_W-1:0]   idSext, idTarget;

    logic [DATA_W-1:0] fwdA, fwdB, aluB, aluOut;
    logic              branchTaken, loadUse, issue;

    assign idOp  = instD[15:12];
    assign idRd  = instD[11:8];
    assign idRs1 = instD[7:4];
    assign idRsB = (idOp == 4'd7 || idOp == 4'd8) ? idRd : instD[3:0];

    always_comb begin
        idRegWrite = 1'b0;
        idMemRead  = 1'b0;
        idMemWrite = 1'b0;
        idBeq      = 1'b0;
        idJmp      = 1'b0;
        idUseImm   = 1'b0;
        idUseA     = 1'b0;
        idUseB     = 1'b0;
        idAluOp    = AluAdd;
        case (idOp)
            4'd1: begin idRegWrite = 1'b1; idUseA = 1'b1; idUseB = 1'b1; idAluOp = AluAdd; end
            4'd2: begin idRegWrite = 1'b1; idUseA = 1'b1; idUseB = 1'b1; idAluOp = AluSub; end
            4'd3: begin idRegWrite = 1'b1; idUseA = 1'b1; idUseB = 1'b1; idAluOp = AluAnd; end
            4'd4: begin idRegWrite = 1'b1; idUseA = 1'b1; idUseB = 1'b1; idAluOp = AluOr;  end
            4'd5: begin idRegWrite = 1'b1; idUseA = 1'b1; idUseImm = 1'b1; end
            4'd6: begin idRegWrite = 1'b1; idMemRead = 1'b1; idUseA = 1'b1; idUseImm = 1'b1; end
            4'd7: begin idMemWrite = 1'b1; idUseA = 1'b1; idUseB = 1'b1; idUseImm = 1'b1; end
            4'd8: begin idBeq = 1'b1; idUseA = 1'b1; idUseB = 1'b1; end
            4'd9: begin idJmp = 1'b1; end
            default: ;
        endcase
        if (ZeroReg && idRd == 4'd0) idRegWrite = 1'b0;
    end

    // Register reads see a same-cycle WB write (write-first).
    always_comb begin
        idA = rf[idRs1];
        idB = rf[idRsB];
        if (wbRegWrite && wbRd == idRs1) idA = wbData;
        if (wbRegWrite && wbRd == idRsB) idB = wbData;
        if (ZeroReg && idRs1 == 4'd0) idA = '0;
        if (ZeroReg && idRsB == 4'd0) idB = '0;
    end

    assign idSext   = PC_W'($signed(instD[3:0]));
    assign idTarget = idJmp ? PC_W'(instD[11:0]) : pcD + PC_W'(1) + idSext;

    // A load in EX/MEM has no data yet, so it is skipped and the older MEM/WB value may apply.
    always_comb begin
        fwdA = exA;
        if (memRegWrite && !memMemRead && memRd == exRs1 && !(ZeroReg && exRs1 == 4'd0))
            fwdA = memAlu;
        else if (wbRegWrite && wbRd == exRs1 && !(ZeroReg && exRs1 == 4'd0))
            fwdA = wbData;
        fwdB = exB;
        if (memRegWrite && !memMemRead && memRd == exRsB && !(ZeroReg && exRsB == 4'd0))
            fwdB = memAlu;
        else if (wbRegWrite && wbRd == exRsB && !(ZeroReg && exRsB == 4'd0))
            fwdB = wbData;
    end

    assign aluB = exUseImm ? DATA_W'(exImm) : fwdB;

    always_comb begin
        aluOut = fwdA + aluB;
        case (exAluOp)
            AluSub:  aluOut = fwdA - aluB;
            AluAnd:  aluOut = fwdA & aluB;
            AluOr:   aluOut = fwdA | aluB;
            default: aluOut = fwdA + aluB;
        endcase
    end

    assign branchTaken = exJmp || (exBeq && fwdA == fwdB);
    assign loadUse     = exMemRead && !(ZeroReg && exRd == 4'd0) &&
                         ((idUseA && idRs1 == exRd) || (idUseB && idRsB == exRd));
    assign issue       = !branchTaken && !loadUse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= ResetPc;
            pcD         <= '0;
            instD       <= '0;
            exRegWrite  <= 1'b0;
            exMemRead   <= 1'b0;
            exMemWrite  <= 1'b0;
            exBeq       <= 1'b0;
            exJmp       <= 1'b0;
            exUseImm    <= 1'b0;
            exAluOp     <= AluAdd;
            exRd        <= '0;
            exRs1       <= '0;
            exRsB       <= '0;
            exImm       <= '0;
            exA         <= '0;
            exB         <= '0;
            exTarget    <= '0;
            memRegWrite <= 1'b0;
            memMemRead  <= 1'b0;
            memMemWrite <= 1'b0;
            memRd       <= '0;
            memAlu      <= '0;
            memStore    <= '0;
            wbRegWrite  <= 1'b0;
            wbRd        <= '0;
            wbData      <= '0;
        end else if (!hold) begin
            wbRegWrite  <= memRegWrite;
            wbRd        <= memRd;
            wbData      <= memMemRead ? dmem_rdata : memAlu;
            memRegWrite <= exRegWrite;
            memMemRead  <= exMemRead;
            memMemWrite <= exMemWrite;
            memRd       <= exRd;
            memAlu      <= aluOut;
            memStore    <= fwdB;
            // Control bits drop to 0 on a flush or stall, turning the ID/EX entry into a bubble.
            exRegWrite  <= idRegWrite & issue;
            exMemRead   <= idMemRead & issue;
            exMemWrite  <= idMemWrite & issue;
            exBeq       <= idBeq & issue;
            exJmp       <= idJmp & issue;
            exUseImm    <= idUseImm;
            exAluOp     <= idAluOp;
            exRd        <= idRd;
            exRs1       <= idRs1;
            exRsB       <= idRsB;
            exImm       <= instD[3:0];
            exA         <= idA;
            exB         <= idB;
            exTarget    <= idTarget;
            if (branchTaken) begin
                pc    <= exTarget;
                instD <= '0;
            end else if (!loadUse) begin
                pc    <= pc + PC_W'(1);
                pcD   <= pc;
                instD <= imem_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (!hold && wbRegWrite && !(ZeroReg && wbRd == 4'd0)) begin
            rf[wbRd] <= wbData;
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = memAlu;
    assign dmem_wdata = memStore;
    assign dmem_we    = memMemWrite && !hold;
    assign wb_valid   = wbRegWrite;
    assign wb_addr    = wbRd;
    assign wb_data    = wbData;

endmodule

// File: tb/tb_pipe_core_param.sv
// Directed bench for pipe_core_param (default parameters, ZERO_REG_EN undefined).
// Instruction and data memories are modelled here; expected values are hand-computed.
module tb_pipe_core_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_we;
    logic [15:0] dmem_rdata;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;

    logic [15:0] imem [4096];
    logic [15:0] dmem [65536];
    int          wrCnt = 0;
    int          wrBase;
    int          testsRun = 0;
    int          failCnt = 0;
    int          cyc = 0;

    pipe_core_param dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
            wrCnt <= wrCnt + 1;
        end
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkWb(input string tag, input logic v, input logic [3:0] a, input logic [15:0] d);
        chk({tag, ".valid"}, 16'(wb_valid), 16'(v));
        if (v) begin
            chk({tag, ".addr"}, 16'(wb_addr), 16'(a));
            chk({tag, ".data"}, wb_data, d);
        end
    endtask

    task automatic clearImem();
        for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic runTo(input int c);
        while (cyc < c) step();
    endtask

    // Holds reset for two cycles and releases it on a falling edge; cyc 0 is the first fetch cycle.
    task automatic applyReset();
        reset = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        clearImem();
        dmem[2] = 16'h1234;
        dmem[3] = 16'h00AA;

        // Reset state and sequential fetch over a NOP stream.
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.imem_addr", 16'(imem_addr), 16'd0);
        chk("rst.dmem_we", 16'(dmem_we), 16'd0);
        chk("rst.wb_valid", 16'(wb_valid), 16'd0);
        chk("rst.wb_addr", 16'(wb_addr), 16'd0);
        chk("rst.wb_data", wb_data, 16'd0);
        applyReset();
        for (int k = 0; k < 4; k++) begin
            chk("fetch.imem_addr", 16'(imem_addr), 16'(k));
            chk("fetch.wb_valid", 16'(wb_valid), 16'd0);
            step();
        end

        // Forwarding from EX/MEM and MEM/WB, write-first bypass, and EX/MEM priority.
        clearImem();
        imem[0] = enc(4'd5, 4'd1, 4'd0, 4'd5);
        imem[1] = enc(4'd1, 4'd2, 4'd1, 4'd1);
        imem[2] = enc(4'd2, 4'd3, 4'd2, 4'd1);
        imem[3] = enc(4'd5, 4'd1, 4'd1, 4'd2);
        imem[4] = enc(4'd5, 4'd1, 4'd1, 4'd1);
        imem[5] = enc(4'd1, 4'd2, 4'd1, 4'd1);
        applyReset();
        runTo(4); chkWb("fwd.r1", 1'b1, 4'd1, 16'd5);
        runTo(5); chkWb("fwd.r2", 1'b1, 4'd2, 16'd10);
        runTo(6); chkWb("fwd.r3", 1'b1, 4'd3, 16'd5);
        chk("fwd.nostall", 16'(imem_addr), 16'd6);
        runTo(7); chkWb("fwd.bypass", 1'b1, 4'd1, 16'd7);
        runTo(8); chkWb("fwd.r1b", 1'b1, 4'd1, 16'd8);
        runTo(9); chkWb("fwd.prio", 1'b1, 4'd2, 16'd16);

        // Load-use stall: one repeated fetch address, then logic ops on forwarded results.
        clearImem();
        imem[0] = enc(4'd6, 4'd4, 4'd0, 4'd3);
        imem[1] = enc(4'd1, 4'd5, 4'd4, 4'd4);
        imem[2] = enc(4'd4, 4'd6, 4'd4, 4'd5);
        imem[3] = enc(4'd3, 4'd7, 4'd5, 4'd6);
        applyReset();
        runTo(2); chk("lu.pc2", 16'(imem_addr), 16'd2);
        runTo(3); chk("lu.pc_repeat", 16'(imem_addr), 16'd2);
        chk("lu.dmem_addr", dmem_addr, 16'd3);
        runTo(4); chk("lu.pc3", 16'(imem_addr), 16'd3);
        chkWb("lu.r4", 1'b1, 4'd4, 16'h00AA);
        runTo(5); chkWb("lu.bubble", 1'b0, 4'd0, 16'd0);
        runTo(6); chkWb("lu.r5", 1'b1, 4'd5, 16'h0154);
        runTo(7); chkWb("lu.or", 1'b1, 4'd6, 16'h01FE);
        runTo(8); chkWb("lu.and", 1'b1, 4'd7, 16'h0154);

        // Taken BEQ and JMP: flushed slots produce no WB.
        clearImem();
        imem[0]  = enc(4'd5, 4'd1, 4'd0, 4'd7);
        imem[1]  = enc(4'd5, 4'd2, 4'd0, 4'd7);
        imem[10] = enc(4'd8, 4'd1, 4'd2, 4'd2);
        imem[11] = enc(4'd5, 4'd6, 4'd0, 4'd1);
        imem[12] = enc(4'd5, 4'd7, 4'd0, 4'd1);
        imem[13] = enc(4'd5, 4'd8, 4'd0, 4'd3);
        imem[14] = enc(4'd9, 4'd0, 4'd1, 4'd4);
        imem[15] = enc(4'd5, 4'd9, 4'd0, 4'd1);
        imem[20] = enc(4'd5, 4'd10, 4'd0, 4'd4);
        applyReset();
        runTo(12); chk("beq.pc12", 16'(imem_addr), 16'd12);
        runTo(13); chk("beq.pc13", 16'(imem_addr), 16'd13);
        runTo(15); chkWb("beq.flush11", 1'b0, 4'd0, 16'd0);
        runTo(16); chkWb("beq.flush12", 1'b0, 4'd0, 16'd0);
        runTo(17); chkWb("beq.r8", 1'b1, 4'd8, 16'd3);
        chk("jmp.pc", 16'(imem_addr), 16'd20);
        runTo(19); chkWb("jmp.flush", 1'b0, 4'd0, 16'd0);
        runTo(21); chkWb("jmp.r10", 1'b1, 4'd10, 16'd4);

        // Not-taken BEQ falls through with no flush.
        imem[1] = enc(4'd5, 4'd2, 4'd0, 4'd8);
        applyReset();
        runTo(13); chk("nbeq.pc13", 16'(imem_addr), 16'd13);
        runTo(15); chkWb("nbeq.r6", 1'b1, 4'd6, 16'd1);
        runTo(16); chkWb("nbeq.r7", 1'b1, 4'd7, 16'd1);
        runTo(17); chkWb("nbeq.r8", 1'b1, 4'd8, 16'd3);

        // Store held in MEM for three cycles, then written exactly once.
        clearImem();
        imem[0] = enc(4'd5, 4'd1, 4'd0, 4'd7);
        imem[1] = enc(4'd7, 4'd1, 4'd0, 4'd2);
        applyReset();
        wrBase = wrCnt;
        runTo(4);
        hold = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("hold.dmem_we", 16'(dmem_we), 16'd0);
            chk("hold.dmem_addr", dmem_addr, 16'd2);
            chk("hold.pc", 16'(imem_addr), 16'd4);
            chkWb("hold.wb", 1'b1, 4'd1, 16'd7);
            step();
        end
        chk("hold.nowrite", dmem[2], 16'h1234);
        hold = 1'b0;
        #1;
        chk("st.dmem_we", 16'(dmem_we), 16'd1);
        chk("st.dmem_addr", dmem_addr, 16'd2);
        chk("st.dmem_wdata", dmem_wdata, 16'd7);
        step();
        chk("st.we_drop", 16'(dmem_we), 16'd0);
        chk("st.mem", dmem[2], 16'd7);
        chk("st.count", 16'(wrCnt - wrBase), 16'd1);

        // Reset while a load is in MEM; regfile must read back as zero afterwards.
        clearImem();
        imem[0] = enc(4'd5, 4'd1, 4'd0, 4'd5);
        imem[2] = enc(4'd6, 4'd4, 4'd0, 4'd3);
        applyReset();
        runTo(5);
        chk("mid.ld_in_mem", dmem_addr, 16'd3);
        reset = 1'b0;
        #1;
        chk("mid.imem_addr", 16'(imem_addr), 16'd0);
        chk("mid.dmem_we", 16'(dmem_we), 16'd0);
        chk("mid.dmem_addr", dmem_addr, 16'd0);
        chk("mid.wb_valid", 16'(wb_valid), 16'd0);
        chk("mid.wb_addr", 16'(wb_addr), 16'd0);
        chk("mid.wb_data", wb_data, 16'd0);
        clearImem();
        imem[0] = enc(4'd1, 4'd9, 4'd1, 4'd1);
        imem[1] = enc(4'd5, 4'd10, 4'd1, 4'd1);
        applyReset();
        runTo(4); chkWb("mid.r9", 1'b1, 4'd9, 16'd0);
        runTo(5); chkWb("mid.r10", 1'b1, 4'd10, 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
        $finish;
    end

endmodule
